// File: rtl/press_pulse_out.sv
// Paced press indicator: each press flag becomes one ON_CYCLES high pulse plus an
// OFF_CYCLES low gap; presses arriving mid-pulse wait in a saturating counter.
`timescale 1ns/1ps
module press_pulse_out #(
  parameter int ON_CYCLES  = 12_500_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int MAX_PEND   = 7,
  localparam int PW        = $clog2(MAX_PEND + 1),
  localparam int CNT_MAX   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES,
  localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          flag_in,
  output logic          led_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [PW-1:0] pending_nx;
  logic          overflow_nx;
  logic          dec;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (pending != '0) state_nx = S_ON;
      end
      S_ON: begin
        if (cnt == ON_LAST) begin
          state_nx = S_OFF;
          cnt_nx   = '0;
        end
      end
      S_OFF: begin
        if (cnt == OFF_LAST) begin
          cnt_nx   = '0;
          state_nx = (pending != '0) ? S_ON : S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // A dequeue is any entry into ON; the decision uses the registered count,
  // so a same-cycle press only becomes visible next cycle.
  always_comb begin
    dec         = (state_nx == S_ON) && (state != S_ON);
    pending_nx  = pending;
    overflow_nx = overflow;
    if (flag_in && !dec) begin
      if (pending == PEND_MAX) overflow_nx = 1'b1;
      else                     pending_nx  = pending + PW'(1);
    end else if (dec && !flag_in) begin
      pending_nx = pending - PW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      led_out  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pending  <= pending_nx;
      overflow <= overflow_nx;
      led_out  <= (state_nx == S_ON);
      busy     <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_press_pulse_out.sv
// Directed bench for press_pulse_out with ON=4, OFF=3, MAX_PEND=3; expected
// waveforms are hand-derived per-cycle strings, one character per cycle.
`timescale 1ns/1ps
module tb_press_pulse_out;
  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int MP  = 3;
  localparam int PW  = $clog2(MP + 1);

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          flag_in = 1'b0;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int ntests = 0;
  int nfail  = 0;

  press_pulse_out #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_PEND(MP)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .flag_in  (flag_in),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish before 200000ns");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(string tag, int idx, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic chk_all(string tag, int idx, logic l, logic b, int p, logic o);
    chk({tag, ".led"},      idx, 32'(led_out),  32'(l));
    chk({tag, ".busy"},     idx, 32'(busy),     32'(b));
    chk({tag, ".pending"},  idx, 32'(pending),  32'(p));
    chk({tag, ".overflow"}, idx, 32'(overflow), 32'(o));
  endtask

  // Character i of press drives flag_in in the cycle before the edge; the
  // other strings give the outputs sampled just after that edge.
  task automatic run_seq(string tag, string press, string led, string bsy,
                         string pend, string ovf);
    for (int i = 0; i < led.len(); i++) begin
      flag_in = (i < press.len()) ? (press[i] == "1") : 1'b0;
      tick();
      chk_all(tag, i, led[i] == "1", bsy[i] == "1", int'(pend[i]) - 48, ovf[i] == "1");
    end
    flag_in = 1'b0;
  endtask

  initial begin
    // Reset held while flag toggles
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      flag_in = i[0];
      tick();
      chk_all("reset_hold", i, 1'b0, 1'b0, 0, 1'b0);
    end
    flag_in = 1'b0;
    rst_n   = 1'b1;
    run_seq("after_release", "", "00000", "00000", "00000", "00000");

    run_seq("single", "1",
            "0111100000", "0111111100", "1000000000", "0000000000");

    run_seq("back2back", "111",
            "01111000111100011110000",
            "01111111111111111111110",
            "11222222111111100000000",
            "00000000000000000000000");

    run_seq("saturate", "11111",
            "011110001111000111100011110000",
            "011111111111111111111111111110",
            "112333332222222111111100000000",
            "000011111111111111111111111111");

    // Reset during second ON cycle with two queued; overflow still set from above
    run_seq("midrst_pre", "111", "011", "011", "112", "111");
    rst_n = 1'b0;
    #1;
    chk_all("midrst_async", 0, 1'b0, 1'b0, 0, 1'b0);
    #2;
    rst_n = 1'b1;
    run_seq("midrst_post", "",
            "00000000000000000000", "00000000000000000000",
            "00000000000000000000", "00000000000000000000");

    // Press lands on the OFF->ON transition with the queue full
    run_seq("coincident", "111100001",
            "011110001111", "011111111111", "112333333333", "000000000000");
    run_seq("coinc_drain", "",
            "0001111000111100011110000",
            "1111111111111111111111110",
            "3332222222111111100000000",
            "0000000000000000000000000");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
